pipeline_ctrl: RTL and testbench

Central stall/flush sequencer for the five-stage ARM pipeline. It turns raw events into per-register freeze and flush controls and into the hazard bubble request for the ID stage:

- ID-stage data hazard.
- EXE-stage branch resolution.
- MEM-stage SRAM wait.

It also runs a post-reset pipeline-clear sequence, a memory-wait watchdog and saturating performance counters.

---
 rtl/pipeline_ctrl_pkg.sv | 15 +
 rtl/sat_counter.sv | 22 ++
 rtl/pipeline_ctrl.sv | 129 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - state encodings and default parameters for pipeline_ctrl
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HOLD     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_ERROR    = 2'd3
    } state_t;

    localparam int DEF_RESET_HOLD  = 2;
    localparam int DEF_MEM_TIMEOUT = 64;
    localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear over increment
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush sequencer with post-reset hold, memory watchdog and counters
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int RESET_HOLD  = DEF_RESET_HOLD,
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard,
    input  logic             ignore_hazard,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             clr_counters,
    output logic             if_freeze,
    output logic             id_hazard,
    output logic             id_freeze,
    output logic             exe_freeze,
    output logic             mem_freeze,
    output logic             if_flush,
    output logic             id_flush,
    output logic             take_branch,
    output logic             mem_timeout,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int HOLD_W = $clog2(RESET_HOLD + 1);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t             state_q;
    state_t             next_state;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               mem_stall;
    logic               hz;
    logic               run_like;

    assign mem_stall = mem_req & ~mem_ready;
    assign hz        = hazard & ~ignore_hazard;
    assign run_like  = (state_q == ST_RUN) || (state_q == ST_MEM_WAIT);
    assign state     = state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_HOLD;
            hold_cnt <= '0;
            wait_cnt <= '0;
        end else begin
            state_q  <= next_state;
            hold_cnt <= (state_q == ST_HOLD) ? hold_cnt + 1'b1 : '0;
            // counts the run of consecutive stalls; any non-stall cycle restarts it
            wait_cnt <= (run_like && mem_stall) ? wait_cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        next_state  = state_q;
        if_freeze   = 1'b0;
        id_hazard   = 1'b0;
        id_freeze   = 1'b0;
        exe_freeze  = 1'b0;
        mem_freeze  = 1'b0;
        if_flush    = 1'b0;
        id_flush    = 1'b0;
        take_branch = 1'b0;
        mem_timeout = 1'b0;
        case (state_q)
            ST_HOLD: begin
                if_freeze = 1'b1;
                if_flush  = 1'b1;
                id_flush  = 1'b1;
                if (hold_cnt == HOLD_LAST) begin
                    next_state = ST_RUN;
                end
            end
            ST_RUN, ST_MEM_WAIT: begin
                if (mem_stall) begin
                    // the whole pipe freezes, so a resolved branch stays latched in EXE/MEM
                    if_freeze  = 1'b1;
                    id_freeze  = 1'b1;
                    exe_freeze = 1'b1;
                    mem_freeze = 1'b1;
                    next_state = (wait_cnt == WAIT_LAST) ? ST_ERROR : ST_MEM_WAIT;
                end else begin
                    next_state = ST_RUN;
                    if (branch_taken) begin
                        take_branch = 1'b1;
                        if_flush    = 1'b1;
                        id_flush    = 1'b1;
                    end else if (hz) begin
                        if_freeze = 1'b1;
                        id_hazard = 1'b1;
                    end
                end
            end
            ST_ERROR: begin
                if_freeze   = 1'b1;
                id_freeze   = 1'b1;
                exe_freeze  = 1'b1;
                mem_freeze  = 1'b1;
                mem_timeout = 1'b1;
            end
            default: next_state = ST_HOLD;
        endcase
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_counters),
        .inc   (run_like && (mem_stall || id_hazard)),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_counters),
        .inc   (take_branch),
        .count (flush_count)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       hazard = 1'b0;
    logic       ignore_hazard = 1'b0;
    logic       branch_taken = 1'b0;
    logic       mem_req = 1'b0;
    logic       mem_ready = 1'b0;
    logic       clr_counters = 1'b0;
    logic       if_freeze, id_hazard, id_freeze, exe_freeze, mem_freeze;
    logic       if_flush, id_flush, take_branch, mem_timeout;
    logic [1:0] state;
    logic [1:0] stall_cycles;
    logic [1:0] flush_count;
    logic [8:0] ctl;

    int total = 0;
    int bad = 0;

    // {if_freeze,id_hazard,id_freeze,exe_freeze,mem_freeze,if_flush,id_flush,take_branch,mem_timeout}
    localparam logic [8:0] C_IDLE   = 9'b000000000;
    localparam logic [8:0] C_HOLD   = 9'b100001100;
    localparam logic [8:0] C_STALL  = 9'b101110000;
    localparam logic [8:0] C_BRANCH = 9'b000001110;
    localparam logic [8:0] C_HAZ    = 9'b110000000;
    localparam logic [8:0] C_ERROR  = 9'b101110001;

    assign ctl = {if_freeze, id_hazard, id_freeze, exe_freeze, mem_freeze,
                  if_flush, id_flush, take_branch, mem_timeout};

    pipeline_ctrl #(.RESET_HOLD(2), .MEM_TIMEOUT(4), .CNT_W(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .hazard        (hazard),
        .ignore_hazard (ignore_hazard),
        .branch_taken  (branch_taken),
        .mem_req       (mem_req),
        .mem_ready     (mem_ready),
        .clr_counters  (clr_counters),
        .if_freeze     (if_freeze),
        .id_hazard     (id_hazard),
        .id_freeze     (id_freeze),
        .exe_freeze    (exe_freeze),
        .mem_freeze    (mem_freeze),
        .if_flush      (if_flush),
        .id_flush      (id_flush),
        .take_branch   (take_branch),
        .mem_timeout   (mem_timeout),
        .state         (state),
        .stall_cycles  (stall_cycles),
        .flush_count   (flush_count)
    );

    always #5 clk = ~clk;

    // inputs change just after the rising edge; checks happen at the falling edge
    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        hazard = 0; ignore_hazard = 0; branch_taken = 0;
        mem_req = 0; mem_ready = 0; clr_counters = 0;
    endtask

    task automatic clear_counters;
        idle_inputs();
        clr_counters = 1;
        cyc();
        clr_counters = 0;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 0;
        repeat (3) cyc();
        #4;
        total++; if (ctl !== C_HOLD) begin bad++; $display("FAIL reset_ctl: got %b want %b", ctl, C_HOLD); end
        total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state); end
        total++; if (stall_cycles !== 2'd0 || flush_count !== 2'd0) begin bad++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cycles, flush_count); end
        cyc();
        rst = 1;
        #4;
        total++; if (ctl !== C_HOLD || state !== 2'd0) begin bad++; $display("FAIL hold_1: got ctl=%b st=%0d want %b st=0", ctl, state, C_HOLD); end
        cyc(); #4;
        total++; if (ctl !== C_HOLD || state !== 2'd0) begin bad++; $display("FAIL hold_2: got ctl=%b st=%0d want %b st=0", ctl, state, C_HOLD); end
        cyc(); #4;
        total++; if (ctl !== C_IDLE || state !== 2'd1) begin bad++; $display("FAIL run_entry: got ctl=%b st=%0d want %b st=1", ctl, state, C_IDLE); end
    endtask

    task automatic test_mem_stall;
        logic [1:0] exp_st [3] = '{2'd1, 2'd2, 2'd2};
        clear_counters();
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #4;
            total++; if (ctl !== C_STALL || state !== exp_st[i]) begin bad++; $display("FAIL mem_stall_%0d: got ctl=%b st=%0d want %b st=%0d", i, ctl, state, C_STALL, exp_st[i]); end
            cyc();
        end
        mem_ready = 1;
        #4;
        total++; if (ctl !== C_IDLE) begin bad++; $display("FAIL mem_release: got %b want %b", ctl, C_IDLE); end
        cyc();
        idle_inputs();
        #4;
        total++; if (state !== 2'd1 || stall_cycles !== 2'd3) begin bad++; $display("FAIL mem_after: got st=%0d stalls=%0d want st=1 stalls=3", state, stall_cycles); end
        cyc();
    endtask

    task automatic test_simultaneous;
        clear_counters();
        branch_taken = 1; hazard = 1;
        #4;
        total++; if (ctl !== C_BRANCH) begin bad++; $display("FAIL br_hz: got %b want %b", ctl, C_BRANCH); end
        cyc();
        idle_inputs();
        #4;
        total++; if (flush_count !== 2'd1 || stall_cycles !== 2'd0) begin bad++; $display("FAIL br_hz_cnt: got fl=%0d st=%0d want 1/0", flush_count, stall_cycles); end
        cyc();
        branch_taken = 1; hazard = 1; mem_req = 1; mem_ready = 0;
        #4;
        total++; if (ctl !== C_STALL) begin bad++; $display("FAIL br_stall: got %b want %b", ctl, C_STALL); end
        cyc();
        mem_ready = 1;
        #4;
        total++; if (ctl !== C_BRANCH) begin bad++; $display("FAIL br_release: got %b want %b", ctl, C_BRANCH); end
        cyc();
        idle_inputs();
        #4;
        total++; if (flush_count !== 2'd2 || stall_cycles !== 2'd1 || state !== 2'd1) begin bad++; $display("FAIL br_release_cnt: got fl=%0d st=%0d state=%0d want 2/1/1", flush_count, stall_cycles, state); end
        cyc();
    endtask

    task automatic test_hazard_filter;
        clear_counters();
        hazard = 1; ignore_hazard = 1;
        #4;
        total++; if (ctl !== C_IDLE) begin bad++; $display("FAIL hz_ignored: got %b want %b", ctl, C_IDLE); end
        cyc();
        ignore_hazard = 0;
        for (int i = 0; i < 2; i++) begin
            #4;
            total++; if (ctl !== C_HAZ) begin bad++; $display("FAIL hz_cycle_%0d: got %b want %b", i, ctl, C_HAZ); end
            cyc();
        end
        idle_inputs();
        #4;
        total++; if (ctl !== C_IDLE || stall_cycles !== 2'd2) begin bad++; $display("FAIL hz_after: got ctl=%b stalls=%0d want %b stalls=2", ctl, stall_cycles, C_IDLE); end
        cyc();
    endtask

    task automatic test_saturation;
        clear_counters();
        branch_taken = 1;
        for (int i = 0; i < 5; i++) begin
            #4;
            total++; if (ctl !== C_BRANCH) begin bad++; $display("FAIL sat_branch_%0d: got %b want %b", i, ctl, C_BRANCH); end
            cyc();
        end
        branch_taken = 0;
        #4;
        total++; if (flush_count !== 2'd3) begin bad++; $display("FAIL sat_flush: got %0d want 3", flush_count); end
        cyc();
        branch_taken = 1; clr_counters = 1;
        #4;
        total++; if (ctl !== C_BRANCH) begin bad++; $display("FAIL clr_branch: got %b want %b", ctl, C_BRANCH); end
        cyc();
        idle_inputs();
        #4;
        total++; if (flush_count !== 2'd0) begin bad++; $display("FAIL clr_wins: got %0d want 0", flush_count); end
        cyc();
    endtask

    task automatic test_watchdog;
        logic [1:0] exp_st [4] = '{2'd1, 2'd2, 2'd2, 2'd2};
        clear_counters();
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 4; i++) begin
            #4;
            total++; if (ctl !== C_STALL || state !== exp_st[i]) begin bad++; $display("FAIL wd_stall_%0d: got ctl=%b st=%0d want %b st=%0d", i, ctl, state, C_STALL, exp_st[i]); end
            cyc();
        end
        #4;
        total++; if (ctl !== C_ERROR || state !== 2'd3) begin bad++; $display("FAIL wd_error: got ctl=%b st=%0d want %b st=3", ctl, state, C_ERROR); end
        total++; if (stall_cycles !== 2'd3) begin bad++; $display("FAIL wd_stalls: got %0d want 3", stall_cycles); end
        cyc();
        mem_ready = 1; mem_req = 0;
        cyc(); #4;
        total++; if (ctl !== C_ERROR || state !== 2'd3) begin bad++; $display("FAIL wd_sticky: got ctl=%b st=%0d want %b st=3", ctl, state, C_ERROR); end
        rst = 0;
        #1;
        total++; if (ctl !== C_HOLD || state !== 2'd0 || stall_cycles !== 2'd0) begin bad++; $display("FAIL wd_reset: got ctl=%b st=%0d stalls=%0d want %b st=0 stalls=0", ctl, state, stall_cycles, C_HOLD); end
        cyc();
        idle_inputs();
        rst = 1;
        cyc(); cyc(); #4;
        total++; if (ctl !== C_IDLE || state !== 2'd1) begin bad++; $display("FAIL wd_rerun: got ctl=%b st=%0d want %b st=1", ctl, state, C_IDLE); end
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not end, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        test_reset();
        cyc();
        test_mem_stall();
        test_simultaneous();
        test_hazard_filter();
        test_saturation();
        test_watchdog();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
